// File: rtl/hp_accum_seq.sv
// Purpose: FP16 accumulation sequencer wrapped around an external combinational adder.
// Latency: the last operand's accept cycle is followed by one ADD cycle, then the result is presented.
// Backpressure: in_ready is low while adding or holding a result; the result is held until out_ready.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_valid/in_ready            operand handshake: in_data (FP16), in_op (1 = subtract), in_last
//   add_a/add_b/add_op           registered operands driven into the external adder
//   add_sum/add_flag             adder result and {UF, OF} flags, combinational from add_a/add_b/add_op
//   out_valid/out_ready          result handshake: out_sum, out_flag (sticky), out_count (saturating)
module hp_accum_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_op,
    input  logic             in_last,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_op,
    input  logic [15:0]      add_sum,
    input  logic [1:0]       add_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [1:0]       out_flag,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [15:0]      acc_q;
    logic [15:0]      b_q;
    logic             op_q;
    logic             last_q;
    logic [1:0]       flag_q;
    logic [CNT_W-1:0] cnt_q;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ADD;
            S_ADD:   state_d = last_q ? S_DONE : S_IDLE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs, decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The adder sees add_a/add_b/add_op stable for the whole ADD
    // cycle; its result is captured unconditionally, even when flags are raised,
    // so NaN/Inf patterns propagate into the sum while the flags stay sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 16'h0000;
            b_q    <= 16'h0000;
            op_q   <= 1'b0;
            last_q <= 1'b0;
            flag_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        b_q    <= in_data;
                        op_q   <= in_op;
                        last_q <= in_last;
                    end
                end
                S_ADD: begin
                    acc_q  <= add_sum;
                    flag_q <= flag_q | add_flag;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    // Clearing on consume means the next accumulation starts from +0.
                    if (out_ready) begin
                        acc_q  <= 16'h0000;
                        flag_q <= 2'b00;
                        cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a     = acc_q;
    assign add_b     = b_q;
    assign add_op    = op_q;
    assign out_sum   = acc_q;
    assign out_flag  = flag_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_hp_accum_seq.sv
module tb_hp_accum_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_op;
    logic        in_last;
    logic        out_ready;
    logic [15:0] resp_sum;
    logic [1:0]  resp_flag;

    // Main instance (CNT_W = 8)
    logic        in_ready, out_valid, add_op;
    logic [15:0] add_a, add_b, out_sum;
    logic [1:0]  out_flag;
    logic [7:0]  out_count;

    // Narrow-counter instance (CNT_W = 2), driven in lockstep
    logic        in_ready2, out_valid2, add_op2;
    logic [15:0] add_a2, add_b2, out_sum2;
    logic [1:0]  out_flag2;
    logic [1:0]  out_count2;

    always #5 clk = ~clk;

    hp_accum_seq #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_sum(resp_sum), .add_flag(resp_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_flag(out_flag),
        .out_count(out_count)
    );

    hp_accum_seq #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_op(in_op), .in_last(in_last),
        .add_a(add_a2), .add_b(add_b2), .add_op(add_op2), .add_sum(resp_sum), .add_flag(resp_flag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_flag(out_flag2),
        .out_count(out_count2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
    } add_exp_t;

    typedef struct {
        logic [15:0] sum;
        logic [1:0]  flag;
        logic [7:0]  cnt8;
        logic [1:0]  cnt2;
    } res_exp_t;

    add_exp_t add_q[$];
    res_exp_t res_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ad_seen = 0;

    // Reference model of the running accumulation
    logic [15:0] acc_m = 16'h0000;
    logic [1:0]  flag_m = 2'b00;
    int          cnt_m = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: ADD cycles are the only cycles with both handshakes low.
    always @(negedge clk) begin
        if (!rst) begin
            if (!in_ready && !out_valid) begin
                ad_seen++;
                if (add_q.size() > 0) begin
                    add_exp_t e;
                    e = add_q.pop_front();
                    check("add_a", add_a, e.a);
                    check("add_b", add_b, e.b);
                    check("add_op", add_op, e.op);
                end else begin
                    check("add_unexpected", 1, 0);
                end
            end
            if (out_valid && out_ready) begin
                if (res_q.size() > 0) begin
                    res_exp_t r;
                    r = res_q.pop_front();
                    check("out_sum", out_sum, r.sum);
                    check("out_flag", out_flag, r.flag);
                    check("out_count", out_count, r.cnt8);
                    check("out_count_w2", out_count2, r.cnt2);
                end else begin
                    check("out_unexpected", 1, 0);
                end
            end
        end
    end

    // Drive one operand with its scripted adder response; returns after the
    // ADD edge. waits = cycles spent waiting for in_ready.
    task automatic send(input logic [15:0] d, input logic op, input logic last,
                        input logic [15:0] rs, input logic [1:0] rf, output int waits);
        add_exp_t ae;
        res_exp_t re;
        bit ok;
        ae.a = acc_m; ae.b = d; ae.op = op;
        add_q.push_back(ae);
        acc_m  = rs;
        flag_m = flag_m | rf;
        cnt_m++;
        if (last) begin
            re.sum  = acc_m;
            re.flag = flag_m;
            re.cnt8 = (cnt_m > 255) ? 8'd255 : 8'(cnt_m);
            re.cnt2 = (cnt_m > 3) ? 2'd3 : 2'(cnt_m);
            res_q.push_back(re);
            acc_m = 16'h0000; flag_m = 2'b00; cnt_m = 0;
        end
        in_data = d; in_op = op; in_last = last; in_valid = 1'b1;
        resp_sum = rs; resp_flag = rf;
        ok = 1'b0;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                waits = i;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (last) check("out_valid_latency", out_valid, 1);
        else      check("back_to_idle", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int ad0;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_op = 1'b0; in_last = 1'b0;
        out_ready = 1'b1; resp_sum = 16'h0; resp_flag = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_add_a", add_a, 16'h0000);
        check("rst_add_b", add_b, 16'h0000);
        check("rst_add_op", add_op, 0);
        check("rst_out_flag", out_flag, 0);
        check("rst_out_count", out_count, 0);

        // Two-element sum
        send(16'h4900, 1'b0, 1'b0, 16'h4900, 2'b00, w);
        send(16'h4500, 1'b0, 1'b1, 16'h4B80, 2'b00, w);
        @(posedge clk); #1;

        // Subtract path
        send(16'h4500, 1'b1, 1'b1, 16'hC500, 2'b00, w);
        @(posedge clk); #1;

        // Sticky flags, then clear on consume
        send(16'h3C00, 1'b0, 1'b0, 16'h3C00, 2'b01, w);
        send(16'h3C00, 1'b0, 1'b0, 16'h4000, 2'b00, w);
        send(16'h3C00, 1'b0, 1'b1, 16'h7E00, 2'b10, w);
        @(posedge clk); #1;
        check("clr_out_sum", out_sum, 16'h0000);
        check("clr_out_flag", out_flag, 0);
        check("clr_out_count", out_count, 0);
        check("clr_in_ready", in_ready, 1);

        // Backpressure with a pending operand
        out_ready = 1'b0;
        send(16'h3C00, 1'b0, 1'b1, 16'h3C00, 2'b01, w);
        in_data = 16'h4000; in_op = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        ad0 = ad_seen;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_sum", out_sum, 16'h3C00);
            check("bp_out_flag", out_flag, 2'b01);
            check("bp_out_count", out_count, 1);
        end
        check("bp_no_accept", ad_seen - ad0, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h4000, 1'b0, 1'b1, 16'h4200, 2'b00, w);
        check("bp_accept_next_cycle", w, 1);
        @(posedge clk); #1;

        // Counter saturation (CNT_W = 2 instance saturates at 3)
        ad0 = ad_seen;
        for (int i = 1; i <= 5; i++) begin
            send(16'h3C00, 1'b0, (i == 5), 16'h3C00 + 16'(i), 2'b00, w);
        end
        check("sat_add_captures", ad_seen - ad0, 5);
        @(posedge clk); #1;

        // Reset while an operand is in flight
        send(16'h4900, 1'b0, 1'b0, 16'h4900, 2'b00, w);
        in_data = 16'h4500; in_op = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        resp_sum = 16'h4B80; resp_flag = 2'b11;
        @(negedge clk);
        check("mid_accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        acc_m = 16'h0000; flag_m = 2'b00; cnt_m = 0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_add_a", add_a, 16'h0000);
        check("mid_rst_out_sum", out_sum, 16'h0000);
        check("mid_rst_out_flag", out_flag, 0);
        check("mid_rst_out_count", out_count, 0);
        @(negedge clk);
        check("mid_rst_idle_hold", in_ready, 1);

        check("add_q_drained", add_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
